// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: opcodes, FSM encoding and instruction layout.
package alu_issue_ctrl_pkg;

  localparam int unsigned INSTR_W = 11;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned STATE_W = 2;

  // Field positions inside the 11-bit instruction word
  localparam int unsigned LI_BIT   = 10;
  localparam int unsigned OP_LSB   = 7;
  localparam int unsigned DST_LSB  = 4;
  localparam int unsigned SRC1_LSB = 2;
  localparam int unsigned SRC2_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [SEL_W-1:0] OP_ADD    = 3'd0;
  localparam logic [SEL_W-1:0] OP_SUB    = 3'd1;
  localparam logic [SEL_W-1:0] OP_AND    = 3'd2;
  localparam logic [SEL_W-1:0] OP_OR     = 3'd3;
  localparam logic [SEL_W-1:0] OP_ROL_RS = 3'd4;
  localparam logic [SEL_W-1:0] OP_ASR_RT = 3'd5;
  localparam logic [SEL_W-1:0] OP_EQ     = 3'd6;
  localparam logic [SEL_W-1:0] OP_GT     = 3'd7;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_OPER = 2'd1;
  localparam logic [STATE_W-1:0] ST_WB   = 2'd2;

  // Decoded view of the instruction word; for li, {src1, src2} is the immediate
  typedef struct packed {
    logic             li;
    logic [SEL_W-1:0] op;
    logic             pad;
    logic [1:0]       dst;
    logic [1:0]       src1;
    logic [1:0]       src2;
  } instr_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the ALU issue controller: two operand read ports, a debug
// read port and one synchronous write port, all entries cleared on reset.
module alu_issue_regfile #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned REG_NUM = 4,
  parameter int unsigned ADDR_W  = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a_c,
  output logic [DATA_W-1:0] rdata_b_c,
  output logic [DATA_W-1:0] dbg_data_c
);

  logic [DATA_W-1:0] mem_q [REG_NUM];
  logic [DATA_W-1:0] mem_d [REG_NUM];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_c  = mem_q[raddr_a];
  assign rdata_b_c  = mem_q[raddr_b];
  assign dbg_data_c = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit ALU: accepts instructions, reads operands,
// drives the combinational ALU, writes the result back and pulses done.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned REG_NUM = 4
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [INSTR_W-1:0]         instr,
  output logic                       instr_ready,
  output logic [SEL_W-1:0]           alu_sel,
  output logic [DATA_W-1:0]          alu_rs,
  output logic [DATA_W-1:0]          alu_rt,
  input  logic [DATA_W-1:0]          alu_rd,
  output logic                       done,
  output logic [DATA_W-1:0]          done_data,
  input  logic [$clog2(REG_NUM)-1:0] dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int unsigned ADDR_W = $clog2(REG_NUM);

  instr_t iw;
  logic   instr_pad_unused;

  assign iw               = instr_t'(instr);
  assign instr_pad_unused = iw.pad;

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]  alu_rs_q, alu_rs_d;
  logic [DATA_W-1:0]  alu_rt_q, alu_rt_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  done_data_q, done_data_d;
  logic               ready_q, ready_d;

  logic               rf_we_c;
  logic [DATA_W-1:0]  rs_c;
  logic [DATA_W-1:0]  rt_c;

  alu_issue_regfile #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk        (CLK),
    .rst_n      (rst_n),
    .we         (rf_we_c),
    .waddr      (dst_q),
    .wdata      (result_q),
    .raddr_a    (ADDR_W'(iw.src1)),
    .raddr_b    (ADDR_W'(iw.src2)),
    .dbg_addr   (dbg_addr),
    .rdata_a_c  (rs_c),
    .rdata_b_c  (rt_c),
    .dbg_data_c (dbg_data)
  );

  // Next-state and datapath update; write-back happens in WB so the next accept sees it
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    result_d    = result_q;
    alu_sel_d   = alu_sel_q;
    alu_rs_d    = alu_rs_q;
    alu_rt_d    = alu_rt_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    rf_we_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          dst_d = ADDR_W'(iw.dst);
          if (iw.li) begin
            result_d = DATA_W'({iw.src1, iw.src2});
            state_d  = ST_WB;
          end else begin
            alu_sel_d = iw.op;
            alu_rs_d  = rs_c;
            alu_rt_d  = rt_c;
            state_d   = ST_OPER;
          end
        end
      end
      ST_OPER: begin
        result_d = alu_rd;
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we_c     = 1'b1;
        done_d      = 1'b1;
        done_data_d = result_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered and tracks the state we are about to enter
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dst_q       <= '0;
      result_q    <= '0;
      alu_sel_q   <= '0;
      alu_rs_q    <= '0;
      alu_rt_q    <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      result_q    <= result_d;
      alu_sel_q   <= alu_sel_d;
      alu_rs_q    <= alu_rs_d;
      alu_rt_q    <= alu_rt_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      ready_q     <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_sel     = alu_sel_q;
  assign alu_rs      = alu_rs_q;
  assign alu_rt      = alu_rt_q;
  assign done        = done_q;
  assign done_data   = done_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, multi-cycle corner
// sequences and random instructions checked against a register-level model.
module tb_alu_issue_ctrl;

  logic        CLK;
  logic        rst_n;
  logic        instr_valid;
  logic [10:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_rs;
  logic [3:0]  alu_rt;
  logic [3:0]  alu_rd;
  logic        done;
  logic [3:0]  done_data;
  logic [1:0]  dbg_addr;
  logic [3:0]  dbg_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] ref_rf [4];

  alu_issue_ctrl dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_sel     (alu_sel),
    .alu_rs      (alu_rs),
    .alu_rt      (alu_rt),
    .alu_rd      (alu_rd),
    .done        (done),
    .done_data   (done_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in for the external ALU; shifts/rotates are by one position
  function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return 4'(a + b);
      3'd1:    return 4'(a - b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return {a[2:0], a[3]};
      3'd5:    return {b[3], b[3:1]};
      3'd6:    return {3'b000, a == b};
      default: return {3'b000, a > b};
    endcase
  endfunction

  always_comb alu_rd = alu_fn(alu_sel, alu_rs, alu_rt);

  function automatic logic [10:0] enc(input logic [2:0] op, input logic [1:0] d,
                                      input logic [1:0] s1, input logic [1:0] s2);
    return {1'b0, op, 1'b0, d, s1, s2};
  endfunction

  function automatic logic [10:0] enc_li(input logic [1:0] d, input logic [3:0] imm);
    return {1'b1, 3'b000, 1'b0, d, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'd0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one instruction, then check operands in OPER, latency, result, debug readback and pulse width
  task automatic run_instr(input logic [10:0] ins, input logic [3:0] exp_d, input int exp_lat, input string nm);
    int n;
    logic [1:0] d, s1, s2;
    d  = ins[5:4];
    s1 = ins[3:2];
    s2 = ins[1:0];
    @(negedge CLK);
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (!instr_ready) begin
      chk({nm, " ready_timeout"}, 32'(instr_ready), 32'd1);
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    dbg_addr = d;
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    n = 1;
    if (!ins[10]) begin
      #1;
      chk({nm, " alu_sel"}, 32'(alu_sel), 32'(ins[9:7]));
      chk({nm, " alu_rs"}, 32'(alu_rs), 32'(ref_rf[s1]));
      chk({nm, " alu_rt"}, 32'(alu_rt), 32'(ref_rf[s2]));
    end
    while (!done && n < 8) begin
      @(negedge CLK);
      n++;
    end
    #1;
    chk({nm, " done_seen"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " done_data"}, 32'(done_data), 32'(exp_d));
    chk({nm, " dbg_wb"}, 32'(dbg_data), 32'(exp_d));
    ref_rf[d] = exp_d;
    @(negedge CLK);
    #1;
    chk({nm, " done_pulse_end"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [10:0] ins;
    logic [3:0]  exp_d;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tbl [7];

  int          acc [2];
  logic [3:0]  dq [2];
  int          done_cyc;
  int          na, nd, ndone;
  logic [3:0]  last_dd;

  initial begin
    // Directed program: constants derived by hand
    tbl[0] = '{enc_li(2'd0, 4'd5),         4'd5,  2, "li_r0_5"};
    tbl[1] = '{enc_li(2'd1, 4'd3),         4'd3,  2, "li_r1_3"};
    tbl[2] = '{enc(3'd0, 2'd2, 2'd0, 2'd1), 4'd8,  3, "add_r2"};
    tbl[3] = '{enc(3'd1, 2'd3, 2'd1, 2'd0), 4'd14, 3, "sub_r3_wrap"};
    tbl[4] = '{enc(3'd7, 2'd2, 2'd0, 2'd1), 4'd1,  3, "gt_r2"};
    tbl[5] = '{enc_li(2'd2, 4'd8),         4'd8,  2, "li_r2_8"};
    tbl[6] = '{enc(3'd5, 2'd3, 2'd0, 2'd2), 4'd12, 3, "asr_r3"};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    model_reset();

    // Reset values
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst instr_ready", 32'(instr_ready), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst done_data", 32'(done_data), 32'd0);
    chk("rst alu_sel", 32'(alu_sel), 32'd0);
    chk("rst alu_rs", 32'(alu_rs), 32'd0);
    chk("rst alu_rt", 32'(alu_rt), 32'd0);
    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk($sformatf("rst dbg r%0d", a), 32'(dbg_data), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].ins, tbl[i].exp_d, tbl[i].lat, tbl[i].nm);
      if (i == 1) begin
        dbg_addr = 2'd0;
        #1;
        chk("preload dbg r0", 32'(dbg_data), 32'd5);
        dbg_addr = 2'd1;
        #1;
        chk("preload dbg r1", 32'(dbg_data), 32'd3);
      end
    end

    // Back-to-back ADD r0 = r0 + r0 with valid held high, r0 = 5
    @(negedge CLK);
    instr = enc(3'd0, 2'd0, 2'd0, 2'd0);
    instr_valid = 1'b1;
    na = 0;
    nd = 0;
    done_cyc = -1;
    for (int k = 0; k < 20 && nd < 2; k++) begin
      #1;
      if (done) begin
        dq[nd] = done_data;
        if (nd == 0) done_cyc = cyc;
        nd++;
      end
      if (instr_valid && instr_ready && na < 2) begin
        acc[na] = cyc;
        na++;
      end
      @(negedge CLK);
      if (na >= 2) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    chk("b2b accepts", 32'(na), 32'd2);
    chk("b2b dones", 32'(nd), 32'd2);
    if (na == 2 && nd == 2) begin
      chk("b2b spacing", 32'(acc[1] - acc[0]), 32'd3);
      chk("b2b accept_with_done", 32'(done_cyc), 32'(acc[1]));
      chk("b2b first", 32'(dq[0]), 32'd10);
      chk("b2b second", 32'(dq[1]), 32'd4);
    end
    ref_rf[0] = 4'd4;

    // Busy ignore: instr changes to li r1=9 during OPER, valid dropped in WB
    @(negedge CLK);
    instr = enc(3'd0, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    instr = enc_li(2'd1, 4'd9);
    @(negedge CLK);
    instr_valid = 1'b0;
    ndone = 0;
    last_dd = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      #1;
      if (done) begin
        ndone++;
        last_dd = done_data;
      end
    end
    chk("busy done_count", 32'(ndone), 32'd1);
    chk("busy done_data", 32'(last_dd), 32'd7);
    dbg_addr = 2'd1;
    #1;
    chk("busy r1_unchanged", 32'(dbg_data), 32'd3);
    ref_rf[2] = 4'd7;

    // Reset during WB of ADD r2 aborts the write-back
    apply_reset();
    run_instr(enc_li(2'd0, 4'd5), 4'd5, 2, "post_rst li_r0");
    run_instr(enc_li(2'd1, 4'd3), 4'd3, 2, "post_rst li_r1");
    @(negedge CLK);
    instr = enc(3'd0, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    rst_n = 1'b0;
    #1;
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst ready", 32'(instr_ready), 32'd1);
    @(negedge CLK);
    rst_n = 1'b1;
    model_reset();
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      if (done) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);
    dbg_addr = 2'd2;
    #1;
    chk("midrst r2_zero", 32'(dbg_data), 32'd0);
    run_instr(enc_li(2'd2, 4'd6), 4'd6, 2, "midrst recover");

    // Random instructions against the register model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [1:0]  d, s1, s2;
      logic [3:0]  imm;
      op  = 3'($urandom_range(0, 7));
      d   = 2'($urandom_range(0, 3));
      s1  = 2'($urandom_range(0, 3));
      s2  = 2'($urandom_range(0, 3));
      imm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) begin
        run_instr(enc_li(d, imm), imm, 2, $sformatf("rnd%0d li", i));
      end else begin
        run_instr(enc(op, d, s1, s2), alu_fn(op, ref_rf[s1], ref_rf[s2]), 3,
                  $sformatf("rnd%0d op%0d", i, op));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    for (int a = 0; a < 4; a++) begin
      dbg_addr = 2'(a);
      #1;
      chk($sformatf("final dbg r%0d", a), 32'(dbg_data), 32'(ref_rf[a]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
